// File: rtl/udp_tx_arbiter_if.sv
// Bus interfaces for udp_tx_arbiter: a byte-wide AXI-stream channel and the UDP header bus.
// Handshake rule for both: a transfer occurs on a rising clock edge where valid && ready; valid never depends on ready.

interface udp_tx_axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

interface udp_tx_hdr_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport master (
    output hdr_valid,
    output ip_dscp,
    output ip_ecn,
    output ip_ttl,
    output ip_source_ip,
    output ip_dest_ip,
    output source_port,
    output dest_port,
    output length,
    output checksum,
    input  hdr_ready
  );

  modport slave (
    input  hdr_valid,
    input  ip_dscp,
    input  ip_ecn,
    input  ip_ttl,
    input  ip_source_ip,
    input  ip_dest_ip,
    input  source_port,
    input  dest_port,
    input  length,
    input  checksum,
    output hdr_ready
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Two-channel round-robin frame scheduler for the UDP TX path: one header per frame, MAX_LEN cap, inter-frame gap.
// Optional statistics counters are built when UDP_TX_ARB_STATS_EN is defined.

module udp_tx_arbiter #(
  parameter logic [31:0] DEST_IP     = {8'd239, 8'd2, 8'd2, 8'd6},
  parameter logic [15:0] DEST_PORT_0 = 16'd21007,
  parameter logic [15:0] DEST_PORT_1 = 16'd21008,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int unsigned MAX_LEN     = 1472,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic               tx_clk,
  input  logic               tx_rst,
  input  logic [31:0]        local_ip,
  input  logic [15:0]        src_port,
  udp_tx_axis_if.slave       s0,
  udp_tx_axis_if.slave       s1,
  udp_tx_hdr_if.master       tx_udp_hdr,
  udp_tx_axis_if.master      tx_udp_payload_axis,
  output logic               grant,
  output logic               busy,
  output logic               status_truncated,
  output logic [31:0]        frame_count_0,
  output logic [31:0]        frame_count_1,
  output logic [31:0]        trunc_count,
  output logic [2:0]         state_dbg
);

  localparam logic [15:0] LAST_BEAT = 16'(MAX_LEN - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DROP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        busy_q, busy_d;
  logic        trunc_q, trunc_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] dport_q, dport_d;
  logic [15:0] sport_q, sport_d;
  logic [31:0] sip_q, sip_d;

  // View of whichever channel currently owns the output.
  logic [7:0] g_tdata;
  logic       g_tvalid;
  logic       g_tlast;
  logic       g_tuser;

  always_comb begin
    if (grant_q) begin
      g_tdata  = s1.tdata;
      g_tvalid = s1.tvalid;
      g_tlast  = s1.tlast;
      g_tuser  = s1.tuser;
    end else begin
      g_tdata  = s0.tdata;
      g_tvalid = s0.tvalid;
      g_tlast  = s0.tlast;
      g_tuser  = s0.tuser;
    end
  end

  logic in_data;
  logic in_drop;
  logic pass_hs;
  logic drop_hs;
  logic trunc_beat;
  logic pick;

  assign in_data    = (state_q == S_DATA);
  assign in_drop    = (state_q == S_DROP);
  assign pass_hs    = in_data && g_tvalid && tx_udp_payload_axis.tready;
  assign drop_hs    = in_drop && g_tvalid;
  // Beat number MAX_LEN without a source tlast: the frame is cut here.
  assign trunc_beat = (beat_q == LAST_BEAT) && !g_tlast;
  // Both requesting: the channel that did not go last wins; otherwise the sole requester.
  assign pick       = (s0.tvalid && s1.tvalid) ? ~last_grant_q : s1.tvalid;

  assign tx_udp_payload_axis.tdata  = g_tdata;
  assign tx_udp_payload_axis.tvalid = in_data && g_tvalid;
  assign tx_udp_payload_axis.tlast  = g_tlast || trunc_beat;
  assign tx_udp_payload_axis.tuser  = g_tuser || trunc_beat;

  assign s0.tready = !grant_q && (in_drop || (in_data && tx_udp_payload_axis.tready));
  assign s1.tready =  grant_q && (in_drop || (in_data && tx_udp_payload_axis.tready));

  assign tx_udp_hdr.hdr_valid    = hdr_valid_q;
  assign tx_udp_hdr.ip_dscp      = 6'd0;
  assign tx_udp_hdr.ip_ecn       = 2'd0;
  assign tx_udp_hdr.ip_ttl       = TTL;
  assign tx_udp_hdr.ip_source_ip = sip_q;
  assign tx_udp_hdr.ip_dest_ip   = DEST_IP;
  assign tx_udp_hdr.source_port  = sport_q;
  assign tx_udp_hdr.dest_port    = dport_q;
  assign tx_udp_hdr.length       = 16'd0;
  assign tx_udp_hdr.checksum     = 16'd0;

  assign grant            = grant_q;
  assign busy             = busy_q;
  assign status_truncated = trunc_q;
  assign state_dbg        = state_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    dport_d      = dport_q;
    sport_d      = sport_q;
    sip_d        = sip_q;
    trunc_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (s0.tvalid || s1.tvalid) begin
          grant_d      = pick;
          last_grant_d = pick;
          dport_d      = pick ? DEST_PORT_1 : DEST_PORT_0;
          sip_d        = local_ip;
          sport_d      = src_port;
          beat_d       = 16'd0;
          state_d      = S_HDR;
        end
      end
      S_HDR: begin
        if (tx_udp_hdr.hdr_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if (pass_hs) begin
          beat_d = beat_q + 16'd1;
          if (g_tlast) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else if (trunc_beat) begin
            state_d = S_DROP;
            trunc_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (drop_hs && g_tlast) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        // Leaving when the counter is at 1 or 0 gives GAP_CYCLES idle cycles, minimum one.
        gap_d = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;
        if (gap_q <= 16'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    hdr_valid_d = (state_d == S_HDR);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hdr_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      trunc_q      <= 1'b0;
      beat_q       <= 16'd0;
      gap_q        <= 16'd0;
      dport_q      <= 16'd0;
      sport_q      <= 16'd0;
      sip_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hdr_valid_q  <= hdr_valid_d;
      busy_q       <= busy_d;
      trunc_q      <= trunc_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      dport_q      <= dport_d;
      sport_q      <= sport_d;
      sip_q        <= sip_d;
    end
  end

`ifdef UDP_TX_ARB_STATS_EN
  logic [31:0] fc0_q, fc0_d;
  logic [31:0] fc1_q, fc1_d;
  logic [31:0] tc_q, tc_d;
  logic        out_last_hs;

  assign out_last_hs = pass_hs && tx_udp_payload_axis.tlast;

  always_comb begin
    fc0_d = fc0_q + {31'd0, out_last_hs && !grant_q};
    fc1_d = fc1_q + {31'd0, out_last_hs &&  grant_q};
    tc_d  = tc_q  + {31'd0, trunc_q};
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      fc0_q <= 32'd0;
      fc1_q <= 32'd0;
      tc_q  <= 32'd0;
    end else begin
      fc0_q <= fc0_d;
      fc1_q <= fc1_d;
      tc_q  <= tc_d;
    end
  end

  assign frame_count_0 = fc0_q;
  assign frame_count_1 = fc1_q;
  assign trunc_count   = tc_q;
`else
  assign frame_count_0 = 32'd0;
  assign frame_count_1 = 32'd0;
  assign trunc_count   = 32'd0;
`endif

endmodule
